// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB camera configuration sequencer.
// Holds the FSM encoding, the ROM table markers and the default timings.
package sccb_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

  localparam int DEF_DELAY_CYCLES = 240000;
  localparam int DEF_GAP_CYCLES   = 64;

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter shared by the inter-transaction gap and settle delay.
// It holds at zero once expired until the next load.
module cfg_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera register ROM and issues one SCCB write per entry,
// with settle delays, NACK retries and held done/error status.
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int MAX_RETRY    = 3
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Start_i,
  output logic [ROM_AW-1:0] Rom_Addr_o,
  input  logic [15:0]       Rom_Data_i,
  output logic              Req_o,
  output logic [7:0]        Addr_o,
  output logic [7:0]        Data_o,
  input  logic              Busy_i,
  input  logic              Done_i,
  input  logic              Nack_i,
  output logic              Config_Done_o,
  output logic              Error_o,
  output logic              Busy_o
);

  localparam int MAXC = (DELAY_CYCLES > GAP_CYCLES) ?
                        DELAY_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t            state, state_n;
  logic              start_q;
  logic              start_pulse;
  logic [ROM_AW-1:0] addr_q, addr_n;
  logic [RW-1:0]     retry_q, retry_n, retry_inc;
  logic [7:0]        reg_a_q, reg_a_n;
  logic [7:0]        reg_d_q, reg_d_n;
  logic              adv_q, adv_n;
  logic              tmr_load;
  logic [CW-1:0]     tmr_val;
  logic              tmr_exp;

  assign start_pulse = Start_i & ~start_q;
  assign retry_inc   = retry_q + 1'b1;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      addr_q  <= '0;
      retry_q <= '0;
      reg_a_q <= '0;
      reg_d_q <= '0;
      adv_q   <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= Start_i;
      addr_q  <= addr_n;
      retry_q <= retry_n;
      reg_a_q <= reg_a_n;
      reg_d_q <= reg_d_n;
      adv_q   <= adv_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    retry_n  = retry_q;
    reg_a_n  = reg_a_q;
    reg_d_n  = reg_d_q;
    adv_n    = adv_q;
    tmr_load = 1'b0;
    tmr_val  = CW'(GAP_CYCLES);
    Req_o    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_pulse) begin
          addr_n  = '0;
          retry_n = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (Rom_Data_i == END_MARKER) begin
          state_n = S_DONE;
        end else if (Rom_Data_i == DELAY_MARKER) begin
          tmr_load = 1'b1;
          tmr_val  = CW'(DELAY_CYCLES);
          state_n  = S_DELAY;
        end else begin
          reg_a_n = Rom_Data_i[15:8];
          reg_d_n = Rom_Data_i[7:0];
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!Busy_i) begin
          Req_o   = 1'b1;
          state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (Done_i) begin
          tmr_load = 1'b1;
          if (!Nack_i) begin
            retry_n = '0;
            adv_n   = 1'b1;
            state_n = S_GAP;
          end else begin
            retry_n = retry_inc;
            adv_n   = 1'b0;
            state_n = (retry_inc == RW'(MAX_RETRY)) ? S_ERROR : S_GAP;
          end
        end
      end
      S_GAP, S_DELAY: begin
        if (tmr_exp) begin
          if (state == S_GAP && !adv_q) begin
            state_n = S_ISSUE;
          end else if (&addr_q) begin
            // last ROM slot consumed: implicit end, address not wrapped
            state_n = S_DONE;
          end else begin
            addr_n  = addr_q + 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  cfg_delay_timer #(
    .W(CW)
  ) u_timer (
    .clk     (Clk_i),
    .rst     (Reset_i),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  assign Rom_Addr_o    = addr_q;
  assign Addr_o        = reg_a_q;
  assign Data_o        = reg_d_q;
  assign Config_Done_o = (state == S_DONE);
  assign Error_o       = (state == S_ERROR);
  assign Busy_o        = !(state inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: ROM model plus an ACK/NACK SCCB slave model,
// hand-computed expectations for each table scenario.
module tb_sccb_config_sequencer;

  localparam int AW = 2;
  localparam int DLY = 300;
  localparam int GAP = 64;

  logic          clk = 1'b0;
  logic          Reset_i = 1'b1;
  logic          Start_i = 1'b0;
  logic [AW-1:0] Rom_Addr_o;
  logic [15:0]   rom_q = '0;
  logic          Req_o;
  logic [7:0]    Addr_o, Data_o;
  logic          Busy_i = 1'b0;
  logic          Done_i = 1'b0;
  logic          Nack_i = 1'b0;
  logic          Config_Done_o, Error_o, Busy_o;

  logic [15:0] rom [4];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          ack_lat = 5;
  int          nack_left = 0;
  logic [7:0]  nack_addr = 8'h00;
  logic [15:0] log_q [$];
  int          req_cyc_q [$];
  int          done_cyc_q [$];
  int          start_cyc;
  int          fall_cyc;

  sccb_config_sequencer #(
    .ROM_AW(AW), .DELAY_CYCLES(DLY),
    .GAP_CYCLES(GAP), .MAX_RETRY(3)
  ) dut (
    .Clk_i(clk), .Reset_i(Reset_i), .Start_i(Start_i),
    .Rom_Addr_o(Rom_Addr_o), .Rom_Data_i(rom_q),
    .Req_o(Req_o), .Addr_o(Addr_o), .Data_o(Data_o),
    .Busy_i(Busy_i), .Done_i(Done_i), .Nack_i(Nack_i),
    .Config_Done_o(Config_Done_o), .Error_o(Error_o),
    .Busy_o(Busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[Rom_Addr_o];
  end

  // every cycle Req_o is high is logged, so a 2-cycle pulse shows up
  always @(negedge clk) begin
    if (Req_o) begin
      log_q.push_back({Addr_o, Data_o});
      req_cyc_q.push_back(cyc);
    end
  end

  always begin
    logic nk;
    @(negedge clk);
    if (Req_o) begin
      nk = (Addr_o == nack_addr) || (nack_left > 0);
      if (nack_left > 0) nack_left = nack_left - 1;
      repeat (ack_lat) @(posedge clk);
      #1;
      Done_i = 1'b1;
      Nack_i = nk;
      done_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
      Done_i = 1'b0;
      Nack_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    log_q.delete();
    req_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic start();
    Start_i = 1'b1;
    start_cyc = cyc;
    tick(1);
    Start_i = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(Config_Done_o || Error_o) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tick(3);
    chk("rst_req", 32'(Req_o), 32'd0);
    chk("rst_busy", 32'(Busy_o), 32'd0);
    chk("rst_done", 32'(Config_Done_o), 32'd0);
    chk("rst_err", 32'(Error_o), 32'd0);
    chk("rst_addr", 32'(Rom_Addr_o), 32'd0);
    Reset_i = 1'b0;
    tick(2);

    // write, settle delay, write, end marker
    rom = '{16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF};
    clr_logs();
    start();
    wait_end("t1_to", 5000);
    chk("t1_n", log_q.size(), 2);
    chk("t1_w0", 32'(log_q[0]), 32'h1280);
    chk("t1_w1", 32'(log_q[1]), 32'h1104);
    chk("t1_lat", req_cyc_q[0] - start_cyc, 3);
    chk("t1_dly", 32'((req_cyc_q[1] - done_cyc_q[0]) >= DLY), 32'd1);
    chk("t1_done", 32'(Config_Done_o), 32'd1);
    chk("t1_err", 32'(Error_o), 32'd0);
    chk("t1_busy", 32'(Busy_o), 32'd0);

    // two NACKs then ACK on the same entry
    rom = '{16'h3A04, 16'h1111, 16'hFFFF, 16'hFFFF};
    clr_logs();
    nack_left = 2;
    start();
    wait_end("t2_to", 5000);
    chk("t2_n", log_q.size(), 4);
    chk("t2_w0", 32'(log_q[0]), 32'h3A04);
    chk("t2_w1", 32'(log_q[1]), 32'h3A04);
    chk("t2_w2", 32'(log_q[2]), 32'h3A04);
    chk("t2_w3", 32'(log_q[3]), 32'h1111);
    chk("t2_sp1", 32'((req_cyc_q[1] - req_cyc_q[0]) >= GAP + 1), 32'd1);
    chk("t2_sp2", 32'((req_cyc_q[2] - req_cyc_q[1]) >= GAP + 1), 32'd1);
    chk("t2_done", 32'(Config_Done_o), 32'd1);

    // entry 1 always NACKed -> error, then restart
    rom = '{16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF};
    clr_logs();
    nack_addr = 8'h22;
    start();
    wait_end("t3_to", 5000);
    chk("t3_err", 32'(Error_o), 32'd1);
    chk("t3_done", 32'(Config_Done_o), 32'd0);
    chk("t3_addr", 32'(Rom_Addr_o), 32'd1);
    tick(200);
    chk("t3_n", log_q.size(), 4);
    chk("t3_w3", 32'(log_q[3]), 32'h2222);
    nack_addr = 8'h00;
    clr_logs();
    start();
    chk("t3_rerr", 32'(Error_o), 32'd0);
    chk("t3_raddr", 32'(Rom_Addr_o), 32'd0);
    chk("t3_rbusy", 32'(Busy_o), 32'd1);
    wait_end("t3_rto", 5000);
    chk("t3_rdone", 32'(Config_Done_o), 32'd1);
    chk("t3_rw0", 32'(log_q[0]), 32'h1111);

    // SCCB master busy for 50 cycles at ISSUE
    rom = '{16'h4455, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    clr_logs();
    Busy_i = 1'b1;
    start();
    tick(50);
    chk("t4_hold", log_q.size(), 0);
    Busy_i = 1'b0;
    fall_cyc = cyc;
    tick(1);
    chk("t4_req", 32'(Req_o), 32'd0);
    chk("t4_n", log_q.size(), 1);
    chk("t4_when", req_cyc_q[0] - fall_cyc, 0);
    wait_end("t4_to", 5000);
    chk("t4_w0", 32'(log_q[0]), 32'h4455);

    // no end marker: all four slots, no wrap
    rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    clr_logs();
    start();
    wait_end("t5_to", 5000);
    chk("t5_n", log_q.size(), 4);
    chk("t5_w3", 32'(log_q[3]), 32'h0404);
    chk("t5_addr", 32'(Rom_Addr_o), 32'd3);
    chk("t5_done", 32'(Config_Done_o), 32'd1);

    // reset while waiting for the ACK; the late Done must be ignored
    rom = '{16'h5566, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    clr_logs();
    ack_lat = 30;
    start();
    tick(5);
    chk("t6_busy", 32'(Busy_o), 32'd1);
    #2;
    Reset_i = 1'b1;
    #1;
    chk("t6_rbusy", 32'(Busy_o), 32'd0);
    chk("t6_rreq", 32'(Req_o), 32'd0);
    chk("t6_rdone", 32'(Config_Done_o), 32'd0);
    tick(1);
    Reset_i = 1'b0;
    tick(40);
    chk("t6_idle", 32'(Busy_o), 32'd0);
    chk("t6_cd", 32'(Config_Done_o), 32'd0);
    chk("t6_n", log_q.size(), 1);
    ack_lat = 5;
    start();
    chk("t6_addr", 32'(Rom_Addr_o), 32'd0);
    wait_end("t6_to", 5000);
    chk("t6_n2", log_q.size(), 2);
    chk("t6_w1", 32'(log_q[1]), 32'h5566);
    chk("t6_done", 32'(Config_Done_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
